// File: rtl/re_demapper.sv
// re_demapper: walks allocated subcarriers of each PUSCH symbol in the grid and splits REs into DMRS and data streams
module re_demapper #(
    parameter int FFT_Len  = 18,
    parameter int Total_Sc = 1200
) (
    input  logic                      CLK_RE,
    input  logic                      RST_RE,
    input  logic                      Start,
    input  logic [10:0]               N_sc,
    input  logic [6:0]                N_rb,
    input  logic [3:0]                Sym_Start,
    input  logic [3:0]                Sym_End,
    input  logic [3:0]                Dmrs_Sym,
    input  logic                      Dmrs_Data_En,
    input  logic                      Sym_Ready,
    output logic                      Rd_en,
    output logic [10:0]               Rd_addr,
    output logic [3:0]                Rd_sym,
    input  logic signed [FFT_Len-1:0] Rd_I,
    input  logic signed [FFT_Len-1:0] Rd_Q,
    output logic signed [FFT_Len-1:0] Dmrs_I,
    output logic signed [FFT_Len-1:0] Dmrs_Q,
    output logic                      Dmrs_Valid,
    output logic [9:0]                Dmrs_Idx,
    output logic signed [FFT_Len-1:0] Data_I,
    output logic signed [FFT_Len-1:0] Data_Q,
    output logic                      Data_Valid,
    output logic                      Data_Last,
    output logic                      Sym_Done,
    output logic                      RE_Done,
    output logic                      Cfg_Err,
    output logic                      Busy
);
    typedef enum logic [2:0] {IDLE, WAIT_SYM, READ, DRAIN, DONE} state_t;

    state_t      state_q, state_d;
    logic [10:0] n_sc_q, n_sc_d, n_re_q, n_re_d, k_q, k_d;
    logic [3:0]  sym_end_q, sym_end_d, dmrs_sym_q, dmrs_sym_d, sym_cnt_q, sym_cnt_d, credit_q, credit_d;
    logic        dmrs_en_q, dmrs_en_d, drain_q, drain_d, cfg_err_q, cfg_err_d;
    logic [11:0] cfg_bound;
    logic        cfg_ok, go_read, rd_last;

    logic        t_v_q, t_odd_q, t_dmrs_q, t_last_q;
    logic [9:0]  t_idx_q;
    logic        dmrs_hit, data_hit;
    logic signed [FFT_Len-1:0] dmrs_i_q, dmrs_q_q, data_i_q, data_q_q;
    logic        dmrs_v_q, data_v_q, data_last_q, sym_done_q;
    logic [9:0]  dmrs_idx_q;

    assign cfg_bound = {1'b0, N_sc} + 12'(N_rb) * 12'd12;
    assign cfg_ok    = (N_rb != 7'd0) && (Sym_Start <= Sym_End) && (cfg_bound <= 12'(Total_Sc));
    assign go_read   = (state_q == WAIT_SYM) && ((credit_q != 4'd0) || Sym_Ready);
    assign rd_last   = k_q == n_re_q - 11'd1;

    // next-state: slot sequencing, symbol/RE counters and symbol credit
    always_comb begin
        state_d    = state_q;
        n_sc_d     = n_sc_q;
        n_re_d     = n_re_q;
        sym_end_d  = sym_end_q;
        dmrs_sym_d = dmrs_sym_q;
        dmrs_en_d  = dmrs_en_q;
        sym_cnt_d  = sym_cnt_q;
        k_d        = k_q;
        drain_d    = drain_q;
        cfg_err_d  = 1'b0;
        credit_d   = (state_q == IDLE) ? 4'd0 :
                     (Sym_Ready && !go_read) ? ((credit_q == 4'd14) ? credit_q : credit_q + 4'd1) :
                     (go_read && !Sym_Ready) ? credit_q - 4'd1 : credit_q;
        case (state_q)
            IDLE: begin
                if (Start && cfg_ok) begin
                    state_d    = WAIT_SYM;
                    n_sc_d     = N_sc;
                    n_re_d     = 11'(N_rb) * 11'd12;
                    sym_end_d  = Sym_End;
                    dmrs_sym_d = Dmrs_Sym;
                    dmrs_en_d  = Dmrs_Data_En;
                    sym_cnt_d  = Sym_Start;
                end
                cfg_err_d = Start && !cfg_ok;
            end
            WAIT_SYM: begin
                state_d = go_read ? READ : WAIT_SYM;
                k_d     = 11'd0;
            end
            READ: begin
                k_d     = k_q + 11'd1;
                state_d = rd_last ? DRAIN : READ;
                drain_d = 1'b0;
            end
            DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d   = (sym_cnt_q == sym_end_q) ? DONE : WAIT_SYM;
                    sym_cnt_d = (sym_cnt_q == sym_end_q) ? sym_cnt_q : sym_cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // control state register
    always_ff @(posedge CLK_RE or negedge RST_RE) begin
        if (!RST_RE) begin
            state_q    <= IDLE;
            n_sc_q     <= '0;
            n_re_q     <= '0;
            sym_end_q  <= '0;
            dmrs_sym_q <= '0;
            dmrs_en_q  <= 1'b0;
            sym_cnt_q  <= '0;
            k_q        <= '0;
            drain_q    <= 1'b0;
            credit_q   <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_sc_q     <= n_sc_d;
            n_re_q     <= n_re_d;
            sym_end_q  <= sym_end_d;
            dmrs_sym_q <= dmrs_sym_d;
            dmrs_en_q  <= dmrs_en_d;
            sym_cnt_q  <= sym_cnt_d;
            k_q        <= k_d;
            drain_q    <= drain_d;
            credit_q   <= credit_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign Rd_en   = state_q == READ;
    assign Rd_addr = Rd_en ? n_sc_q + k_q : 11'd0;
    assign Rd_sym  = Rd_en ? sym_cnt_q : 4'd0;

    // the routing decision uses the tag that travelled alongside the read
    assign dmrs_hit = t_v_q && t_dmrs_q && !t_odd_q;
    assign data_hit = t_v_q && (!t_dmrs_q || (t_odd_q && dmrs_en_q));

    // read tag stage and registered output stage; I/Q hold when not valid
    always_ff @(posedge CLK_RE or negedge RST_RE) begin
        if (!RST_RE) begin
            t_v_q       <= 1'b0;
            t_odd_q     <= 1'b0;
            t_dmrs_q    <= 1'b0;
            t_last_q    <= 1'b0;
            t_idx_q     <= '0;
            dmrs_v_q    <= 1'b0;
            data_v_q    <= 1'b0;
            data_last_q <= 1'b0;
            sym_done_q  <= 1'b0;
            dmrs_idx_q  <= '0;
            dmrs_i_q    <= '0;
            dmrs_q_q    <= '0;
            data_i_q    <= '0;
            data_q_q    <= '0;
        end else begin
            t_v_q       <= Rd_en;
            t_odd_q     <= k_q[0];
            t_dmrs_q    <= sym_cnt_q == dmrs_sym_q;
            t_last_q    <= Rd_en && rd_last;
            t_idx_q     <= k_q[10:1];
            dmrs_v_q    <= dmrs_hit;
            data_v_q    <= data_hit;
            data_last_q <= data_hit && t_last_q;
            sym_done_q  <= t_v_q && t_last_q;
            if (dmrs_hit) begin
                dmrs_idx_q <= t_idx_q;
                dmrs_i_q   <= Rd_I;
                dmrs_q_q   <= Rd_Q;
            end
            if (data_hit) begin
                data_i_q <= Rd_I;
                data_q_q <= Rd_Q;
            end
        end
    end

    assign Dmrs_I     = dmrs_i_q;
    assign Dmrs_Q     = dmrs_q_q;
    assign Dmrs_Valid = dmrs_v_q;
    assign Dmrs_Idx   = dmrs_idx_q;
    assign Data_I     = data_i_q;
    assign Data_Q     = data_q_q;
    assign Data_Valid = data_v_q;
    assign Data_Last  = data_last_q;
    assign Sym_Done   = sym_done_q;
    assign RE_Done    = state_q == DONE;
    assign Cfg_Err    = cfg_err_q;
    assign Busy       = state_q != IDLE;
endmodule

// File: tb/tb_re_demapper.sv
// tb_re_demapper: random and directed slots checked against a read-list model of the grid walk
module tb_re_demapper;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0, dmrs_en = 1'b0, sym_ready = 1'b0;
    logic [10:0] n_sc = '0;
    logic [6:0] n_rb = '0;
    logic [3:0] sym_start = '0, sym_end = '0, dmrs_sym = '0;
    logic rd_en, dmrs_valid, data_valid, data_last, sym_done, re_done, cfg_err, busy;
    logic [10:0] rd_addr;
    logic [3:0] rd_sym;
    logic signed [17:0] rd_i = '0, rd_q = '0, dmrs_i, dmrs_q, data_i, data_q;
    logic [9:0] dmrs_idx;

    re_demapper dut (
        .CLK_RE(clk), .RST_RE(rst_n), .Start(start), .N_sc(n_sc), .N_rb(n_rb),
        .Sym_Start(sym_start), .Sym_End(sym_end), .Dmrs_Sym(dmrs_sym), .Dmrs_Data_En(dmrs_en),
        .Sym_Ready(sym_ready), .Rd_en(rd_en), .Rd_addr(rd_addr), .Rd_sym(rd_sym),
        .Rd_I(rd_i), .Rd_Q(rd_q), .Dmrs_I(dmrs_i), .Dmrs_Q(dmrs_q), .Dmrs_Valid(dmrs_valid),
        .Dmrs_Idx(dmrs_idx), .Data_I(data_i), .Data_Q(data_q), .Data_Valid(data_valid),
        .Data_Last(data_last), .Sym_Done(sym_done), .RE_Done(re_done), .Cfg_Err(cfg_err), .Busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v; logic [3:0] sym; logic [10:0] addr; logic [10:0] k;
        logic dmrs; logic data; logic last; logic fin;
    } ent_t;

    logic [17:0] grid_i [16][1200];
    logic [17:0] grid_q [16][1200];
    ent_t exp_rd[$];
    ent_t e1, e2, cur;
    logic re_due = 1'b0;
    logic model_busy = 1'b0;
    int checks = 0, errors = 0, cyc = 0;
    int n_dmrs, n_data, n_sym_done, n_re_done, n_reads, first_out_cyc, last_out_cyc;
    int rdy_cnt, started, last_idx, last_addr;
    logic [17:0] first_dmrs_i, first_dmrs_q;
    int first_rd_cyc [16];
    int last_rd_cyc [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // grid memory: data valid one cycle after the read strobe
    always @(posedge clk) if (rd_en) begin
        rd_i <= grid_i[rd_sym][rd_addr];
        rd_q <= grid_q[rd_sym][rd_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    // compare process: outputs now belong to the read seen two cycles ago
    always @(negedge clk) begin
        if (!rst_n) begin
            e1.v = 1'b0; e2.v = 1'b0; re_due = 1'b0;
        end else begin
            chk("dmrs_valid", 32'(dmrs_valid), 32'(e2.v && e2.dmrs));
            chk("data_valid", 32'(data_valid), 32'(e2.v && e2.data));
            chk("sym_done", 32'(sym_done), 32'(e2.v && e2.last));
            chk("data_last", 32'(data_last), 32'(e2.v && e2.data && e2.last));
            chk("re_done", 32'(re_done), 32'(re_due));
            if (e2.v && e2.dmrs) begin
                chk("dmrs_i", 32'($unsigned(dmrs_i)), 32'(grid_i[e2.sym][e2.addr]));
                chk("dmrs_q", 32'($unsigned(dmrs_q)), 32'(grid_q[e2.sym][e2.addr]));
                chk("dmrs_idx", 32'(dmrs_idx), 32'(e2.k / 2));
                if (n_dmrs == 0) begin first_dmrs_i = dmrs_i; first_dmrs_q = dmrs_q; end
                n_dmrs++;
                last_idx = int'(dmrs_idx);
            end
            if (e2.v && e2.data) begin
                chk("data_i", 32'($unsigned(data_i)), 32'(grid_i[e2.sym][e2.addr]));
                chk("data_q", 32'($unsigned(data_q)), 32'(grid_q[e2.sym][e2.addr]));
                n_data++;
            end
            if (sym_done) n_sym_done++;
            if (re_done) n_re_done++;
            if (dmrs_valid || data_valid) begin
                if (first_out_cyc < 0) first_out_cyc = cyc;
                last_out_cyc = cyc;
            end
            re_due = e2.v && e2.fin;
            cur.v = 1'b0;
            if (rd_en) begin
                chk("read_expected", 32'(exp_rd.size() != 0), 32'd1);
                if (exp_rd.size() != 0) begin
                    cur = exp_rd.pop_front();
                    chk("rd_addr", 32'(rd_addr), 32'(cur.addr));
                    chk("rd_sym", 32'(rd_sym), 32'(cur.sym));
                    n_reads++;
                    last_addr = int'(rd_addr);
                    if (cur.k == 0) begin
                        chk("pacing", 32'(started < rdy_cnt), 32'd1);
                        started++;
                        first_rd_cyc[cur.sym] = cyc;
                    end
                    if (cur.last) last_rd_cyc[cur.sym] = cyc;
                end
            end
            if (model_busy && sym_ready) rdy_cnt++;
            e2 = e1;
            e1 = cur;
        end
    end

    task automatic clear_stats();
        n_dmrs = 0; n_data = 0; n_sym_done = 0; n_re_done = 0; n_reads = 0;
        first_out_cyc = -1; last_out_cyc = -1; last_idx = -1; last_addr = -1;
    endtask

    task automatic start_slot(input int nsc, input int nrb, input int ss, input int se, input int dm, input int en);
        bit valid;
        valid = (nrb != 0) && (ss <= se) && (nsc + 12 * nrb <= 1200);
        @(posedge clk); #1;
        n_sc = 11'(nsc); n_rb = 7'(nrb); sym_start = 4'(ss); sym_end = 4'(se);
        dmrs_sym = 4'(dm); dmrs_en = en[0]; start = 1'b1;
        if (valid) for (int s = ss; s <= se; s++) for (int k = 0; k < 12 * nrb; k++) begin
            ent_t e;
            e.v = 1'b1; e.sym = 4'(s); e.addr = 11'(nsc + k); e.k = 11'(k);
            e.dmrs = (s == dm) && (k % 2 == 0);
            e.data = (s != dm) || ((k % 2 == 1) && en[0]);
            e.last = k == 12 * nrb - 1;
            e.fin = e.last && (s == se);
            exp_rd.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk("cfg_err", 32'(cfg_err), 32'(!valid));
        chk("busy_after_start", 32'(busy), 32'(valid));
        model_busy = valid; rdy_cnt = 0; started = 0;
    endtask

    task automatic ready_n(input int n);
        @(posedge clk); #1;
        sym_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1 sym_ready = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((exp_rd.size() != 0 || busy) && n < limit) begin @(negedge clk); n++; end
        chk("slot_completes", 32'(n < limit), 32'd1);
        repeat (2) @(negedge clk);
        model_busy = 1'b0;
    endtask

    initial begin
        for (int s = 0; s < 16; s++) for (int a = 0; a < 1200; a++) begin
            grid_i[s][a] = 18'($urandom);
            grid_q[s][a] = 18'($urandom);
        end
        grid_i[2][0] = 18'h1FFFF;
        grid_q[2][0] = 18'h20000;
        clear_stats();
        #2 rst_n = 1'b0;
        #1;
        chk("reset_rd_en", 32'(rd_en), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_valids", 32'({dmrs_valid, data_valid, sym_done, re_done, cfg_err}), 32'd0);
        chk("reset_data_i", 32'($unsigned(data_i)), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // DMRS symbol without data followed by a data symbol
        clear_stats();
        start_slot(0, 1, 2, 3, 2, 0);
        ready_n(1);
        repeat (10) @(posedge clk);
        ready_n(1);
        wait_idle(500);
        chk("t1_dmrs_count", 32'(n_dmrs), 32'd6);
        chk("t1_data_count", 32'(n_data), 32'd12);
        chk("t1_sym_done", 32'(n_sym_done), 32'd2);
        chk("t1_re_done", 32'(n_re_done), 32'd1);
        chk("t1_last_idx", 32'(last_idx), 32'd5);
        chk("t1_last_addr", 32'(last_addr), 32'd11);
        chk("t1_i_max", 32'(first_dmrs_i), 32'h1FFFF);
        chk("t1_q_neg", 32'(first_dmrs_q), 32'h20000);
        chk("t1_latency", 32'(first_out_cyc - first_rd_cyc[2]), 32'd2);

        // interleaved DMRS/data, plus a Start while busy that must be ignored
        clear_stats();
        start_slot(5, 2, 4, 4, 4, 1);
        ready_n(1);
        repeat (3) @(posedge clk);
        #1 start = 1'b1; n_rb = 7'd0;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_start_no_err", 32'(cfg_err), 32'd0);
        chk("busy_start_busy", 32'(busy), 32'd1);
        wait_idle(500);
        chk("t2_dmrs_count", 32'(n_dmrs), 32'd12);
        chk("t2_data_count", 32'(n_data), 32'd12);
        chk("t2_one_per_cycle", 32'(last_out_cyc - first_out_cyc), 32'd23);

        // rejected configurations and the upper address bound
        clear_stats();
        start_slot(1195, 1, 0, 0, 0, 0);
        ready_n(2);
        repeat (20) @(posedge clk);
        chk("rej_busy", 32'(busy), 32'd0);
        start_slot(0, 0, 0, 1, 0, 0);
        start_slot(0, 1, 5, 3, 0, 0);
        repeat (10) @(posedge clk);
        chk("rej_reads", 32'(n_reads), 32'd0);
        start_slot(1188, 1, 0, 0, 7, 0);
        ready_n(1);
        wait_idle(500);
        chk("bound_last_addr", 32'(last_addr), 32'd1199);

        // credit earned during READ lets the next symbol start right after DRAIN
        clear_stats();
        start_slot(10, 1, 0, 2, 1, 1);
        ready_n(3);
        wait_idle(500);
        chk("gap_0_1", 32'(first_rd_cyc[1] - last_rd_cyc[0]), 32'd4);
        chk("gap_1_2", 32'(first_rd_cyc[2] - last_rd_cyc[1]), 32'd4);

        // credit saturation; Sym_Ready while idle is ignored
        clear_stats();
        ready_n(3);
        repeat (5) @(posedge clk);
        start_slot(0, 2, 0, 15, 0, $urandom_range(0, 1));
        ready_n(16);
        repeat (500) @(posedge clk);
        chk("sat_reads", 32'(n_reads), 32'd360);
        chk("sat_busy", 32'(busy), 32'd1);
        ready_n(1);
        wait_idle(500);
        chk("sat_total_reads", 32'(n_reads), 32'd384);

        // asynchronous reset mid-READ, then a fresh slot
        clear_stats();
        start_slot(100, 4, 1, 3, 2, 1);
        ready_n(1);
        for (int n = 0; n < 200 && n_reads < 6; n++) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valids", 32'({dmrs_valid, data_valid, sym_done}), 32'd0);
        chk("rst_data_i", 32'($unsigned(data_i)), 32'd0);
        exp_rd.delete();
        model_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_stats();
        ready_n(3);
        repeat (30) @(posedge clk);
        chk("post_rst_reads", 32'(n_reads), 32'd0);
        start_slot(0, 1, 2, 3, 2, 0);
        ready_n(2);
        wait_idle(500);
        chk("fresh_dmrs", 32'(n_dmrs), 32'd6);
        chk("fresh_data", 32'(n_data), 32'd12);
        chk("fresh_re_done", 32'(n_re_done), 32'd1);

        // random slots with random symbol pacing
        for (int it = 0; it < 25; it++) begin
            int nrb, nsc, ss, se, hi, dm, en;
            bit valid;
            nrb = $urandom_range(0, 6);
            hi = 1200 - 12 * nrb + (($urandom_range(0, 3) == 0) ? 24 : 0);
            nsc = $urandom_range(0, hi);
            ss = $urandom_range(0, 15);
            se = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(ss, (ss + 3 > 15) ? 15 : ss + 3);
            dm = $urandom_range(0, 15);
            en = $urandom_range(0, 1);
            valid = (nrb != 0) && (ss <= se) && (nsc + 12 * nrb <= 1200);
            start_slot(nsc, nrb, ss, se, dm, en);
            if (valid) begin
                for (int s = ss; s <= se; s++) begin
                    repeat ($urandom_range(0, 40)) @(posedge clk);
                    ready_n(1);
                end
                wait_idle(2000);
            end else repeat (10) @(posedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
